// File: rtl/brq_rf_pkg.sv
// Shared types and register indices for the blocks on the register-file write side.
package brq_rf_pkg;

  typedef enum logic {ARB_INIT, ARB_RUN} arb_state_e;

  localparam int REG_X0 = 0;
  localparam int REG_SP = 2;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester handshakes plus the register-file write port, bundled for the write arbiter.
interface regfile_wr_arbiter_if #(
  parameter int DataWidth    = 32,
  parameter int AddrRegWidth = 5
);

  logic                    alu_valid;
  logic [AddrRegWidth-1:0] alu_rd;
  logic [DataWidth-1:0]    alu_data;
  logic                    alu_ready;
  logic                    lsu_valid;
  logic [AddrRegWidth-1:0] lsu_rd;
  logic [DataWidth-1:0]    lsu_data;
  logic                    lsu_ready;
  logic                    rf_we;
  logic [AddrRegWidth-1:0] rf_waddr;
  logic [DataWidth-1:0]    rf_wdata;
  logic                    init_done;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready, rf_we, rf_waddr, rf_wdata, init_done
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, rf_we, rf_waddr, rf_wdata, init_done
  );

endinterface

// File: rtl/brq_starve_cnt.sv
// Saturating wait counter; hit flags that the blocked requester must now be served.
module brq_starve_cnt #(
  parameter int MaxCount = 4,
  parameter int Width    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [Width-1:0] MaxVal = Width'(MaxCount);

  logic [Width-1:0] cnt;

  assign hit = (cnt == MaxVal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !hit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Owns the regfile write port: sweeps x1..x31 after reset, then arbitrates ALU/LSU writeback.
module regfile_wr_arbiter
  import brq_rf_pkg::*;
#(
  parameter int                   DataWidth    = 32,
  parameter int                   AddrRegWidth = 5,
  parameter logic [DataWidth-1:0] SpInit       = DataWidth'(32'h200),
  parameter int                   MaxWait      = 4
) (
  input logic                 brq_clk,
  input logic                 brq_rst,
  regfile_wr_arbiter_if.slave bus
);

  localparam int                      NumRegs = 2 ** AddrRegWidth;
  localparam logic [AddrRegWidth-1:0] LastIdx = AddrRegWidth'(NumRegs - 1);
  localparam logic [AddrRegWidth-1:0] SpIdx   = AddrRegWidth'(REG_SP);
  localparam logic [AddrRegWidth-1:0] X0Idx   = AddrRegWidth'(REG_X0);

  arb_state_e              state;
  logic [AddrRegWidth-1:0] sweep_idx;
  logic                    rf_we_q;
  logic [AddrRegWidth-1:0] rf_waddr_q;
  logic [DataWidth-1:0]    rf_wdata_q;
  logic                    init_done_q;

  logic                    force_lsu;
  logic                    alu_ready;
  logic                    lsu_ready;
  logic                    alu_acc;
  logic                    lsu_acc;
  logic                    starve_inc;
  logic                    starve_clr;
  logic                    nxt_we;
  logic [AddrRegWidth-1:0] nxt_addr;
  logic [DataWidth-1:0]    nxt_data;

  // Only counts LSU blocking while arbitrating; the sweep is not a starvation event.
  brq_starve_cnt #(
    .MaxCount (MaxWait),
    .Width    (4)
  ) u_starve (
    .clk   (brq_clk),
    .rst_n (brq_rst),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .hit   (force_lsu)
  );

  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (state == ARB_RUN) begin
      lsu_ready = bus.lsu_valid & (force_lsu | ~bus.alu_valid);
      alu_ready = ~(bus.lsu_valid & force_lsu);
    end
  end

  assign alu_acc    = bus.alu_valid & alu_ready;
  assign lsu_acc    = bus.lsu_valid & lsu_ready;
  assign starve_inc = (state == ARB_RUN) & bus.lsu_valid & ~lsu_ready;
  assign starve_clr = ~starve_inc;

  // Writes to x0 complete the handshake but leave the port idle and the address/data held.
  always_comb begin
    nxt_we   = 1'b0;
    nxt_addr = rf_waddr_q;
    nxt_data = rf_wdata_q;
    if (state == ARB_INIT) begin
      nxt_we   = 1'b1;
      nxt_addr = sweep_idx;
      nxt_data = (sweep_idx == SpIdx) ? SpInit : '0;
    end else if (alu_acc) begin
      if (bus.alu_rd != X0Idx) begin
        nxt_we   = 1'b1;
        nxt_addr = bus.alu_rd;
        nxt_data = bus.alu_data;
      end
    end else if (lsu_acc) begin
      if (bus.lsu_rd != X0Idx) begin
        nxt_we   = 1'b1;
        nxt_addr = bus.lsu_rd;
        nxt_data = bus.lsu_data;
      end
    end
  end

  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      state       <= ARB_INIT;
      sweep_idx   <= AddrRegWidth'(1);
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      rf_we_q    <= nxt_we;
      rf_waddr_q <= nxt_addr;
      rf_wdata_q <= nxt_data;
      if (state == ARB_INIT) begin
        if (sweep_idx == LastIdx) begin
          state       <= ARB_RUN;
          init_done_q <= 1'b1;
        end else begin
          sweep_idx <= sweep_idx + 1'b1;
        end
      end
    end
  end

  assign bus.alu_ready = alu_ready;
  assign bus.lsu_ready = lsu_ready;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.init_done = init_done_q;

endmodule
